alu_mdu: RTL and testbench
==========================

ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning datapath width in bits (legal: 8..64, power of two).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port a  input  WIDTH  first operand.
REQ-005 SHALL have port b  input  WIDTH  second operand.
REQ-006 SHALL have port op  input  4  operation select.
REQ-007 SHALL have port start  input  1  launch request for multi-cycle or HI/LO-write ops.
REQ-008 SHALL have port alu_out  output  WIDTH  combinational result of the single-cycle op.
REQ-009 SHALL have port zero  output  1  (a == b).
REQ-010 SHALL have port less_s  output  1  signed a < b.
REQ-011 SHALL have port less_u  output  1  unsigned a < b.
REQ-012 SHALL have port busy  output  1  multi-cycle op in progress.
REQ-013 SHALL have port hi  output  WIDTH  HI register.
REQ-014 SHALL have port lo  output  WIDTH  LO register.

Function
REQ-015 SHALL compute alu_out combinationally in 0 cycles for ADD, SUB, OR, AND, XOR, NOR, SLT, SLTU, SLL, SRL and SRA; all other op values SHALL give alu_out = 0.
REQ-016 SHALL wrap ADD/SUB modulo 2^WIDTH, with no overflow flag.
REQ-017 SHALL take the shift amount from b[log2(WIDTH)-1:0] and shift a; SRA SHALL sign-fill.
REQ-018 SHALL make SLT/SLTU results zero-extended 0/1, and SHALL drive zero, less_s and less_u for every op.
REQ-019 SHALL run an FSM with states IDLE, RUN and FIX.
REQ-020 SHALL, when start=1, busy=0 and op is MULT, MULTU, DIV or DIVU, latch a, b and op, then go IDLE->RUN.
REQ-021 SHALL stay in RUN for exactly WIDTH cycles (shift-add multiply or restoring divide on magnitudes), then go RUN->FIX for 1 cycle, then FIX->IDLE.
REQ-022 SHALL hold busy=1 in RUN and FIX, so busy is high for WIDTH+1 cycles after the start edge.
REQ-023 SHALL write hi/lo only on the FIX->IDLE edge; hi and lo SHALL hold their old values while busy.
REQ-024 SHALL place the 2*WIDTH-bit product in {hi, lo}; signed MULT SHALL negate the product when the operand signs differ.
REQ-025 SHALL place the quotient in lo and the remainder in hi for DIV/DIVU; the quotient SHALL truncate toward zero and the remainder sign SHALL follow the dividend.
REQ-026 SHALL, for divide-by-zero, give lo = all ones and hi = a.
REQ-027 SHALL, for signed DIV of most-negative by -1, give lo = most-negative and hi = 0.
REQ-028 SHALL, when start=1 and busy=0 with op MTHI or MTLO, load a into hi or lo on the next edge, with busy staying 0.
REQ-029 SHALL ignore start while busy=1, with no queuing.
REQ-030 SHALL let single-cycle ops be used while busy, with results unaffected.

Reset
REQ-031 SHALL, on reset at any time (including mid-operation), force the FSM to IDLE and busy=0, hi=0 and lo=0 immediately; combinational outputs SHALL be unaffected.
REQ-032 SHALL discard the in-flight result on reset, and the first start after reset is released SHALL be accepted normally.

Configuration
REQ-033 SHALL, when macro ALU_MDU_DIV_EN is defined, include the divider and provide DIV/DIVU per REQ-025..027.
REQ-034 SHALL, when ALU_MDU_DIV_EN is undefined, synthesise no divider logic and ignore DIV/DIVU with start: busy stays 0, hi and lo are unchanged, and MULT timing is identical.

Structure
REQ-035 SHALL define the op encodings, the FSM state type and the op-class helper constants in shared package alu_pkg.
REQ-036 SHALL implement the iterative multiply/divide datapath and FSM in sub-module mdu_core; alu_mdu SHALL keep the combinational ALU and instantiate mdu_core.

Verification (WIDTH=32, ALU_MDU_DIV_EN defined unless noted)
REQ-037 SHALL cover: ADD a=0x7FFFFFFF b=1 -> alu_out=0x80000000, zero=0; SLT a=0xFFFFFFFF b=1 -> alu_out=1, less_s=1, less_u=0.
REQ-038 SHALL cover: MULT a=0xFFFFFFFD b=7 -> busy high 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-039 SHALL cover: DIV a=0xFFFFFFF9 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=5 b=0 -> lo=0xFFFFFFFF, hi=5.
REQ-040 SHALL cover: MULTU a=3 b=4, a second start at cycle 5 -> ignored, final lo=12, hi=0; then reset asserted at cycle 10 of a new MULTU -> busy=0, hi=0, lo=0 immediately.
REQ-041 SHALL cover: MTHI a=0x1234 with start -> hi=0x1234 next edge, busy never asserts.
REQ-042 SHALL cover: ALU_MDU_DIV_EN undefined, DIV a=8 b=2 with start -> busy stays 0, hi and lo unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: op encodings, FSM state constants and op-class helpers shared by the ALU/MDU slice.
package alu_pkg;
    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_OR    = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_NOR   = 4'h5;
    localparam logic [3:0] OP_SLT   = 4'h6;
    localparam logic [3:0] OP_SLTU  = 4'h7;
    localparam logic [3:0] OP_SLL   = 4'h8;
    localparam logic [3:0] OP_SRL   = 4'h9;
    localparam logic [3:0] OP_SRA   = 4'hA;
    localparam logic [3:0] OP_MULT  = 4'hB;
    localparam logic [3:0] OP_MULTU = 4'hC;
    localparam logic [3:0] OP_DIV   = 4'hD;
    localparam logic [3:0] OP_DIVU  = 4'hE;
    localparam logic [3:0] OP_MTHI  = 4'hF;
    // Seventeen ops in a 4-bit field: MTLO reuses the SRA code and only acts with start.
    localparam logic [3:0] OP_MTLO  = OP_SRA;
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_FIX  = 2'd2;
    function automatic logic is_mul(input logic [3:0] op);
        return op == OP_MULT || op == OP_MULTU;
    endfunction
    function automatic logic is_div(input logic [3:0] op);
        return op == OP_DIV || op == OP_DIVU;
    endfunction
endpackage

// File: rtl/alu_mdu_if.sv
// alu_mdu_if: operand/op/start bus and ALU + HI/LO result bus of alu_mdu.
interface alu_mdu_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] a, b, alu_out, hi, lo;
    logic [3:0] op;
    logic start, zero, less_s, less_u, busy;
    modport master (output a, b, op, start, input alu_out, zero, less_s, less_u, busy, hi, lo);
    modport slave (input a, b, op, start, output alu_out, zero, less_s, less_u, busy, hi, lo);
endinterface

// File: rtl/mdu_core.sv
// mdu_core: iterative shift-add multiplier / restoring divider with HI/LO registers.
// The divider is only built when ALU_MDU_DIV_EN is defined.
module mdu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int W  = WIDTH;
    localparam int CW = $clog2(WIDTH);
    state_t state;
    logic [CW-1:0] cnt;
    logic [2*W-1:0] p, step, mstep, prod;
    logic [W-1:0] mb, ma_n, mb_n, res_hi, res_lo;
    logic [W:0] madd;
    logic go, sgn, sa, sb, neg_q;
    assign busy = state != S_IDLE;
    assign sgn  = op == OP_MULT || op == OP_DIV;
    assign sa   = sgn & a[W-1];
    assign sb   = sgn & b[W-1];
    assign ma_n = sa ? -a : a;
    assign mb_n = sb ? -b : b;
    // {hi,lo} accumulator: carry-out of the add shifts in at the top.
    assign madd  = {1'b0, p[2*W-1:W]} + {1'b0, mb};
    assign mstep = p[0] ? {madd, p[W-1:1]} : {1'b0, p[2*W-1:1]};
    assign prod  = neg_q ? -p : p;
`ifdef ALU_MDU_DIV_EN
    logic div_q, neg_r;
    logic [W:0] rtry, rsub;
    logic [W-1:0] quo, rem;
    assign go    = start && !busy && (is_mul(op) || is_div(op));
    assign rtry  = p[2*W-1:W-1];
    assign rsub  = rtry - {1'b0, mb};
    assign step  = !div_q ? mstep : rtry >= {1'b0, mb} ? {rsub[W-1:0], p[W-2:0], 1'b1} : {rtry[W-1:0], p[W-2:0], 1'b0};
    assign quo   = neg_q ? -p[W-1:0] : p[W-1:0];
    assign rem   = neg_r ? -p[2*W-1:W] : p[2*W-1:W];
    // Divide-by-zero naturally leaves the dividend as remainder; only the quotient needs forcing.
    assign res_lo = div_q ? (mb == '0 ? '1 : quo) : prod[W-1:0];
    assign res_hi = div_q ? rem : prod[2*W-1:W];
`else
    assign go     = start && !busy && is_mul(op);
    assign step   = mstep;
    assign res_lo = prod[W-1:0];
    assign res_hi = prod[2*W-1:W];
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            p     <= '0;
            mb    <= '0;
            neg_q <= 1'b0;
            hi    <= '0;
            lo    <= '0;
`ifdef ALU_MDU_DIV_EN
            div_q <= 1'b0;
            neg_r <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        state <= S_RUN;
                        cnt   <= CW'(W - 1);
                        p     <= {{W{1'b0}}, ma_n};
                        mb    <= mb_n;
                        neg_q <= sa ^ sb;
`ifdef ALU_MDU_DIV_EN
                        div_q <= is_div(op);
                        neg_r <= sa;
`endif
                    end else if (start && op == OP_MTHI) hi <= a;
                    else if (start && op == OP_MTLO) lo <= a;
                end
                S_RUN: begin
                    p   <= step;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= S_FIX;
                end
                default: begin
                    state <= S_IDLE;
                    hi    <= res_hi;
                    lo    <= res_lo;
                end
            endcase
        end
    end
endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: combinational ALU with compare flags, plus the iterative MDU (mdu_core) for HI/LO.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       reset,
    alu_mdu_if.slave  bus
);
    logic [WIDTH-1:0] a, b, r;
    logic [$clog2(WIDTH)-1:0] sh;
    assign a  = bus.a;
    assign b  = bus.b;
    assign sh = b[$clog2(WIDTH)-1:0];
    assign bus.zero   = a == b;
    assign bus.less_s = $signed(a) < $signed(b);
    assign bus.less_u = a < b;
    assign bus.alu_out = r;
    always_comb begin
        case (bus.op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, bus.less_s};
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, bus.less_u};
            OP_SLL:  r = a << sh;
            OP_SRL:  r = a >> sh;
            OP_SRA:  r = $signed(a) >>> sh;
            default: r = '0;
        endcase
    end
    mdu_core #(.WIDTH(WIDTH)) u_mdu (
        .clk  (clk),
        .reset(reset),
        .a    (bus.a),
        .b    (bus.b),
        .op   (bus.op),
        .start(bus.start),
        .busy (bus.busy),
        .hi   (bus.hi),
        .lo   (bus.lo)
    );
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed self-checking bench for alu_mdu (WIDTH=32).
module tb_alu_mdu;
    import alu_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int passed = 0;
    alu_mdu_if #(.WIDTH(32)) bus();
    alu_mdu #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op = op;
        bus.a  = a;
        bus.b  = b;
        #1;
    endtask

    // Launch op, then count negedges with busy high; at busy-cycle 'poke' fire a stray start.
    task automatic mdu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int poke, output int n);
        @(negedge clk);
        bus.op = op;
        bus.a = a;
        bus.b = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.busy && n < 200) begin
            n++;
            if (n == poke) begin
                bus.op = OP_MULTU;
                bus.a = 32'd9;
                bus.b = 32'd9;
                bus.start = 1'b1;
            end else bus.start = 1'b0;
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int n;
        bus.a = '0;
        bus.b = '0;
        bus.op = OP_ADD;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        reset = 1'b0;
        alu(OP_ADD, 32'h7FFFFFFF, 32'd1);
        chk("add_out", bus.alu_out, 32'h80000000);
        chk("add_zero", bus.zero, 0);
        alu(OP_SUB, 32'd5, 32'd5);
        chk("sub_out", bus.alu_out, 0);
        chk("sub_zero", bus.zero, 1);
        alu(OP_SLT, 32'hFFFFFFFF, 32'd1);
        chk("slt_out", bus.alu_out, 1);
        chk("slt_less_s", bus.less_s, 1);
        chk("slt_less_u", bus.less_u, 0);
        alu(OP_SLTU, 32'hFFFFFFFF, 32'd1);
        chk("sltu_out", bus.alu_out, 0);
        alu(OP_SRA, 32'h80000000, 32'd4);
        chk("sra_out", bus.alu_out, 32'hF8000000);
        alu(OP_SRL, 32'h80000000, 32'd4);
        chk("srl_out", bus.alu_out, 32'h08000000);
        alu(OP_SLL, 32'd1, 32'h21);
        chk("sll_out", bus.alu_out, 32'd2);
        alu(OP_NOR, 32'h0F0F0000, 32'h000000F0);
        chk("nor_out", bus.alu_out, 32'hF0F0FF0F);
        alu(OP_XOR, 32'hFF00FF00, 32'h0FF00FF0);
        chk("xor_out", bus.alu_out, 32'hF0F0F0F0);
        alu(OP_MULT, 32'd3, 32'd4);
        chk("mult_alu_out", bus.alu_out, 0);

        mdu(OP_MULT, 32'hFFFFFFFD, 32'd7, 0, n);
        chk("mult_busy_cycles", n, 33);
        chk("mult_hi", bus.hi, 32'hFFFFFFFF);
        chk("mult_lo", bus.lo, 32'hFFFFFFEB);
`ifdef ALU_MDU_DIV_EN
        mdu(OP_DIV, 32'hFFFFFFF9, 32'd2, 0, n);
        chk("div_busy_cycles", n, 33);
        chk("div_lo", bus.lo, 32'hFFFFFFFD);
        chk("div_hi", bus.hi, 32'hFFFFFFFF);
        mdu(OP_DIVU, 32'd5, 32'd0, 0, n);
        chk("divu0_lo", bus.lo, 32'hFFFFFFFF);
        chk("divu0_hi", bus.hi, 32'd5);
        mdu(OP_DIV, 32'hFFFFFFF8, 32'd0, 0, n);
        chk("div0_lo", bus.lo, 32'hFFFFFFFF);
        chk("div0_hi", bus.hi, 32'hFFFFFFF8);
        mdu(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, n);
        chk("divmin_lo", bus.lo, 32'h80000000);
        chk("divmin_hi", bus.hi, 0);
        mdu(OP_DIVU, 32'd100, 32'd7, 0, n);
        chk("divu_lo", bus.lo, 32'd14);
        chk("divu_hi", bus.hi, 32'd2);
`else
        mdu(OP_DIV, 32'd8, 32'd2, 0, n);
        chk("nodiv_busy", n, 0);
        @(negedge clk);
        chk("nodiv_busy_late", bus.busy, 0);
        chk("nodiv_hi", bus.hi, 32'hFFFFFFFF);
        chk("nodiv_lo", bus.lo, 32'hFFFFFFEB);
`endif
        mdu(OP_MULTU, 32'd3, 32'd4, 5, n);
        chk("multu_busy_cycles", n, 33);
        chk("multu_lo", bus.lo, 32'd12);
        chk("multu_hi", bus.hi, 0);

        @(negedge clk);
        bus.op = OP_MTHI;
        bus.a = 32'h1234;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        chk("mthi_busy_edge", bus.busy, 0);
        @(negedge clk);
        bus.start = 1'b0;
        chk("mthi_hi", bus.hi, 32'h1234);
        chk("mthi_busy", bus.busy, 0);
        bus.op = OP_MTLO;
        bus.a = 32'h5678;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("mtlo_lo", bus.lo, 32'h5678);
        chk("mtlo_hi_kept", bus.hi, 32'h1234);

        @(negedge clk);
        bus.op = OP_MULTU;
        bus.a = 32'd3;
        bus.b = 32'd5;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("run_busy", bus.busy, 1);
        chk("run_hi_held", bus.hi, 32'h1234);
        alu(OP_ADD, 32'd2, 32'd3);
        chk("alu_while_busy", bus.alu_out, 32'd5);
        reset = 1'b1;
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_hi", bus.hi, 0);
        chk("midrst_lo", bus.lo, 0);
        chk("midrst_alu", bus.alu_out, 32'd5);
        @(negedge clk);
        reset = 1'b0;
        mdu(OP_MULTU, 32'd2, 32'd3, 0, n);
        chk("post_rst_cycles", n, 33);
        chk("post_rst_lo", bus.lo, 32'd6);
        chk("post_rst_hi", bus.hi, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
